dip_uart_tx: RTL and testbench

Reports trainer DIP switch state to the AVR over the serial link, the FPGA-to-AVR counterpart of the DIP-to-LED path. Synchronises and debounces the 8 switches, mirrors the debounced value on the LEDs, and transmits one 8N1 UART byte on avr_rx each time the debounced value changes. Transmission is gated by the AVR's avr_rx_busy flow-control input. Sits in mojo_top between the trainer_dip pins and the avr_rx/led pins.

---
 rtl/dip_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_dip_uart_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dip_uart_tx.sv
// dip_uart_tx: synchronises and debounces the trainer DIP switches, mirrors
// the debounced value on the LEDs, and sends each new value to the AVR as
// one 8N1 UART byte, held off by the AVR's receive-buffer-full flag.
module dip_uart_tx #(
  parameter int CLK_PER_BIT     = 100,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] trainer_dip,
  input  logic       avr_rx_busy,
  output logic       avr_rx,
  output logic [7:0] led,
  output logic       tx_busy
);

  localparam int TMR_W = $clog2(CLK_PER_BIT);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_PER_BIT - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Synchroniser stages
  logic [7:0] dip_meta_q, dip_s_q;
  logic       busy_meta_q, busy_s_q;

  // Debouncer state
  logic [7:0]      cand_q, cand_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [7:0]      stable_q, stable_d;

  // Transmitter state
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       last_sent_q, last_sent_d;
  logic             avr_rx_q, avr_rx_d;

  logic pending;
  logic launch;

  // Two-flop synchronisers for the asynchronous switch and flow-control inputs
  always_ff @(posedge clk) begin
    // NOTE: every register in an always_ff uses <= so all flops sample the
    // pre-edge values together; a blocking = here would collapse the chain.
    if (rst) begin
      dip_meta_q  <= 8'h00;
      dip_s_q     <= 8'h00;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      dip_meta_q  <= trainer_dip;
      dip_s_q     <= dip_meta_q;
      busy_meta_q <= avr_rx_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  // Vector debouncer: any difference restarts the count, a full run of
  // stable cycles promotes the candidate to the debounced value
  always_comb begin
    // NOTE: defaulting every next-state variable first means no path leaves
    // one unassigned, so no latch can be inferred.
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (dip_s_q != cand_q) begin
      cand_d   = dip_s_q;
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_LAST) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end else begin
      stable_d = cand_q;
    end
  end

  assign pending = (stable_q != last_sent_q);

  // Frame sequencer; a frame may launch from IDLE or straight out of the
  // last STOP cycle so back-to-back frames carry no idle gap
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    last_sent_d = last_sent_q;
    launch      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        launch = pending && !busy_s_q;
      end
      S_START: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_STOP: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (pending && !busy_s_q) launch  = 1'b1;
          else                      state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Snapshot the debounced value; a change landing on this same edge
    // stays pending for the next frame
    if (launch) begin
      shreg_d     = stable_q;
      last_sent_d = stable_q;
      tmr_d       = '0;
      state_d     = S_START;
    end
  end

  // Line level for the coming cycle, registered so avr_rx never glitches
  always_comb begin
    unique case (state_d)
      S_START: avr_rx_d = 1'b0;
      S_DATA:  avr_rx_d = shreg_d[idx_d];
      default: avr_rx_d = 1'b1;
    endcase
  end

  // State registers; reset abandons any frame and returns the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q      <= 8'h00;
      db_cnt_q    <= '0;
      stable_q    <= 8'h00;
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      last_sent_q <= 8'h00;
      avr_rx_q    <= 1'b1;
    end else begin
      cand_q      <= cand_d;
      db_cnt_q    <= db_cnt_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      last_sent_q <= last_sent_d;
      avr_rx_q    <= avr_rx_d;
    end
  end

  assign avr_rx  = avr_rx_q;
  assign led     = stable_q;
  assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dip_uart_tx.sv
// Directed bench for dip_uart_tx with CLK_PER_BIT=4, DEBOUNCE_CYCLES=8.
// Outputs are sampled 1 time unit after each rising edge.
module tb_dip_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] trainer_dip;
  logic       avr_rx_busy;
  logic       avr_rx;
  logic [7:0] led;
  logic       tx_busy;

  int errors = 0;
  int checks = 0;

  dip_uart_tx #(
    .CLK_PER_BIT    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trainer_dip(trainer_dip),
    .avr_rx_busy(avr_rx_busy),
    .avr_rx     (avr_rx),
    .led        (led),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected 40-cycle line pattern, cycle c at bit c: start, 8 data LSB first, stop
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int c = 0; c < 40; c++) begin
      if (c < 4)       f[c] = 1'b0;
      else if (c < 36) f[c] = b[3'((c - 4) / 4)];
      else             f[c] = 1'b1;
    end
    return f;
  endfunction

  // Advance until avr_rx is low; n is the number of edges taken (bounded)
  task automatic wait_fall(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (avr_rx !== 1'b0 && n < max);
  endtask

  // Called at cycle 0 of a frame (start bit already on the line)
  task automatic capture_frame(input logic [7:0] b, input string tag);
    logic [39:0] obs_line, obs_busy;
    for (int c = 0; c < 40; c++) begin
      obs_line[c] = avr_rx;
      obs_busy[c] = tx_busy;
      tick();
    end
    check({tag, "_line"}, 64'(obs_line), 64'(frame_bits(b)));
    check({tag, "_busy"}, 64'(obs_busy), 64'({40{1'b1}}));
  endtask

  // Advance n cycles and report whether avr_rx ever went low
  task automatic watch_idle(input int n, output logic saw_low);
    saw_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (avr_rx !== 1'b1) saw_low = 1'b1;
    end
  endtask

  initial begin
    int   n;
    logic saw_low;

    rst         = 1'b1;
    trainer_dip = 8'hFF;
    avr_rx_busy = 1'b0;

    // Reset state held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_avr_rx", 64'(avr_rx), 64'(1'b1));
      check("rst_led", 64'(led), 64'(8'h00));
      check("rst_tx_busy", 64'(tx_busy), 64'(1'b0));
    end
    rst = 1'b0;

    // 8'hFF reaches led at edge 11, start bit at edge 12
    repeat (10) tick();
    check("rel_led_e10", 64'(led), 64'(8'h00));
    tick();
    check("rel_led_e11", 64'(led), 64'(8'hFF));
    check("rel_rx_e11", 64'(avr_rx), 64'(1'b1));
    tick();
    check("rel_rx_e12", 64'(avr_rx), 64'(1'b0));
    capture_frame(8'hFF, "ff_frame");
    check("ff_end_busy", 64'(tx_busy), 64'(1'b0));
    check("ff_end_rx", 64'(avr_rx), 64'(1'b1));

    // Frame format with 8'hA5
    trainer_dip = 8'hA5;
    wait_fall(40, n);
    check("a5_latency", 64'(n), 64'(12));
    check("a5_led", 64'(led), 64'(8'hA5));
    capture_frame(8'hA5, "a5_frame");
    check("a5_end_busy", 64'(tx_busy), 64'(1'b0));

    // Glitch on bit 0 shorter than the debounce window is ignored
    trainer_dip = 8'hA4;
    repeat (5) tick();
    trainer_dip = 8'hA5;
    watch_idle(25, saw_low);
    check("glitch_no_frame", 64'(saw_low), 64'(1'b0));
    check("glitch_led", 64'(led), 64'(8'hA5));

    // Held change is accepted after 11 edges and sent once
    trainer_dip = 8'hA4;
    repeat (10) tick();
    check("deb_led_e10", 64'(led), 64'(8'hA5));
    tick();
    check("deb_led_e11", 64'(led), 64'(8'hA4));
    tick();
    check("deb_rx_e12", 64'(avr_rx), 64'(1'b0));
    capture_frame(8'hA4, "a4_frame");
    watch_idle(20, saw_low);
    check("a4_single_frame", 64'(saw_low), 64'(1'b0));

    // Flow control: busy holds the frame back, led still updates
    avr_rx_busy = 1'b1;
    trainer_dip = 8'h3C;
    watch_idle(30, saw_low);
    check("fc_held_rx", 64'(saw_low), 64'(1'b0));
    check("fc_led", 64'(led), 64'(8'h3C));
    check("fc_held_busy", 64'(tx_busy), 64'(1'b0));
    avr_rx_busy = 1'b0;
    tick();
    tick();
    check("fc_rel_e2", 64'(avr_rx), 64'(1'b1));
    tick();
    check("fc_rel_e3", 64'(avr_rx), 64'(1'b0));
    // busy rising mid-frame must not truncate the frame
    fork
      capture_frame(8'h3C, "3c_frame");
      begin
        repeat (10) @(posedge clk);
        #1;
        avr_rx_busy = 1'b1;
      end
    join
    check("3c_end_busy", 64'(tx_busy), 64'(1'b0));
    avr_rx_busy = 1'b0;
    watch_idle(10, saw_low);
    check("3c_nothing_pending", 64'(saw_low), 64'(1'b0));

    // Coalescing: 02 then 04 settle during the 01 frame; only 04 follows
    trainer_dip = 8'h01;
    wait_fall(40, n);
    check("01_latency", 64'(n), 64'(12));
    fork
      capture_frame(8'h01, "01_frame");
      begin
        @(posedge clk);
        #1;
        trainer_dip = 8'h02;
        repeat (13) @(posedge clk);
        #1;
        trainer_dip = 8'h04;
      end
    join
    check("coal_led", 64'(led), 64'(8'h04));
    check("coal_b2b_rx", 64'(avr_rx), 64'(1'b0));
    capture_frame(8'h04, "04_frame");
    check("04_end_busy", 64'(tx_busy), 64'(1'b0));
    watch_idle(20, saw_low);
    check("coal_no_third", 64'(saw_low), 64'(1'b0));

    // Reset during data bit 3 of an 8'hF0 frame
    trainer_dip = 8'hF0;
    wait_fall(40, n);
    check("f0_latency", 64'(n), 64'(12));
    repeat (17) tick();
    check("f0_bit3_low", 64'(avr_rx), 64'(1'b0));
    check("f0_bit3_busy", 64'(tx_busy), 64'(1'b1));
    rst = 1'b1;
    tick();
    check("mid_rst_rx", 64'(avr_rx), 64'(1'b1));
    check("mid_rst_busy", 64'(tx_busy), 64'(1'b0));
    check("mid_rst_led", 64'(led), 64'(8'h00));
    tick();
    rst = 1'b0;
    wait_fall(40, n);
    check("f0_resend_latency", 64'(n), 64'(12));
    capture_frame(8'hF0, "f0_frame");
    check("f0_end_busy", 64'(tx_busy), 64'(1'b0));
    check("f0_end_rx", 64'(avr_rx), 64'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
